// File: rtl/zx_mem_pkg.sv
// Shared constants and types for the ZX Spectrum memory mapper.
package zx_mem_pkg;

  // Page register layout
  localparam int unsigned PAGE_REG_W  = 6;
  localparam int unsigned PG_PAGE_LSB = 0;
  localparam int unsigned PG_PAGE_MSB = 2;
  localparam int unsigned PG_SCREEN   = 3;
  localparam int unsigned PG_ROM      = 4;
  localparam int unsigned PG_LOCK     = 5;

  // Pages hard-wired behind 4000-7FFF and 8000-BFFF
  localparam int unsigned FIXED_PAGE_4000 = 5;
  localparam int unsigned FIXED_PAGE_8000 = 2;

  // Wait-state counter holds 0..7
  localparam int unsigned WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    WG_IDLE = 2'd0,
    WG_WAIT = 2'd1,
    WG_DONE = 2'd2
  } wait_state_t;

endpackage

// File: rtl/zx_wait_gen.sv
// Wait-state generator: one nWAIT burst of WAIT_STATES cycles per access to C000-FFFF.
module zx_wait_gen
  import zx_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk_cpu,
  input  logic reset,
  input  logic nMREQ,
  input  logic nRD,
  input  logic nWR,
  input  logic hi_bank,
  output logic nWAIT
);

  wait_state_t             state;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic                    start;

  // Real read/write access to the banked region; refresh (no nRD/nWR) never qualifies
  assign start = (WAIT_STATES != 0) && !nMREQ && (!nRD || !nWR) && hi_bank;

  // FSM, counter and registered nWAIT
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state <= WG_IDLE;
      cnt   <= '0;
      nWAIT <= 1'b1;
    end else begin
      case (state)
        WG_IDLE: begin
          if (start) begin
            state <= WG_WAIT;
            cnt   <= WAIT_CNT_W'(WAIT_STATES);
            nWAIT <= 1'b0;
          end
        end
        WG_WAIT: begin
          if (nMREQ) begin
            state <= WG_IDLE;
            cnt   <= '0;
            nWAIT <= 1'b1;
          end else if (cnt <= WAIT_CNT_W'(1)) begin
            state <= WG_DONE;
            cnt   <= '0;
            nWAIT <= 1'b1;
          end else begin
            cnt <= cnt - WAIT_CNT_W'(1);
          end
        end
        WG_DONE: begin
          // Hold off until the access ends so each access gets a single burst
          if (nMREQ) begin
            state <= WG_IDLE;
          end
        end
        default: begin
          state <= WG_IDLE;
          cnt   <= '0;
          nWAIT <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/zx_mem_mapper.sv
// ZX Spectrum 48K/128K memory mapper: page register, address decode and CPU data-bus steering.
module zx_mem_mapper
  import zx_mem_pkg::*;
#(
  parameter int unsigned RAM_PAGES   = 8,
  parameter int unsigned ROM_BANKS   = 2,
  parameter logic [15:0] PAGE_PORT   = 16'h7FFD,
  parameter logic [15:0] PORT_MASK   = 16'h8002,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          MODE_48K    = 1'b0,
  localparam int unsigned PW = $clog2(RAM_PAGES),
  localparam int unsigned RW = (ROM_BANKS > 1) ? $clog2(ROM_BANKS) : 1
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic [15:0]       A,
  input  logic [7:0]        D_in,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  input  logic [7:0]        rom_q,
  input  logic [7:0]        ram_q,
  input  logic [7:0]        ula_data,
  output logic [7:0]        d_out,
  output logic              d_oe,
  output logic [RW+13:0]    rom_addr,
  output logic [PW+13:0]    ram_addr,
  output logic              ram_we,
  output logic              screen_page,
  output logic [5:0]        page_reg,
  output logic              nWAIT
);

  logic          port_hit;
  logic          hit_q;
  logic [1:0]    region;
  logic [RW-1:0] rom_bank;
  logic [PW-1:0] ram_page;
  logic [1:0]    unused_d;

  assign region   = A[15:14];
  assign unused_d = D_in[7:6];

  // Partial decode of the page port on an I/O write
  assign port_hit = ((A & PORT_MASK) == (PAGE_PORT & PORT_MASK)) && !nIORQ && !nWR;

  // Page register: loads once per I/O cycle on the leading edge of a port hit, frozen by lock
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      page_reg <= '0;
      hit_q    <= 1'b0;
    end else begin
      hit_q <= port_hit;
      if (!MODE_48K && port_hit && !hit_q && !page_reg[PG_LOCK]) begin
        page_reg <= D_in[PAGE_REG_W-1:0];
      end
    end
  end

  assign screen_page = page_reg[PG_SCREEN];

  // ROM bank select; single-bank builds always see bank 0
  assign rom_bank = (ROM_BANKS > 1) ? RW'(page_reg[PG_ROM]) : '0;
  assign rom_addr = {rom_bank, A[13:0]};

  // RAM page per 16K region; page numbers wrap modulo RAM_PAGES by truncation
  always_comb begin
    ram_page = PW'(page_reg[PG_PAGE_MSB:PG_PAGE_LSB]);
    case (region)
      2'b01:   ram_page = PW'(FIXED_PAGE_4000);
      2'b10:   ram_page = PW'(FIXED_PAGE_8000);
      default: ram_page = PW'(page_reg[PG_PAGE_MSB:PG_PAGE_LSB]);
    endcase
  end

  assign ram_addr = {ram_page, A[13:0]};

  // Writes into the ROM region are dropped
  assign ram_we = !nMREQ && !nWR && (region != 2'b00);

  // CPU read-data steering
  always_comb begin
    d_out = 8'hFF;
    d_oe  = 1'b0;
    if (!nMREQ && !nRD) begin
      d_out = (region == 2'b00) ? rom_q : ram_q;
      d_oe  = 1'b1;
    end else if (!nIORQ && !nRD) begin
      d_out = ula_data;
      d_oe  = 1'b1;
    end
  end

  // Wait states for the slow banked region
  zx_wait_gen #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_gen (
    .clk_cpu (clk_cpu),
    .reset   (reset),
    .nMREQ   (nMREQ),
    .nRD     (nRD),
    .nWR     (nWR),
    .hi_bank (region == 2'b11),
    .nWAIT   (nWAIT)
  );

endmodule

// File: tb/tb_zx_mem_mapper.sv
// Randomized bench for zx_mem_mapper: three parameter builds checked against a behavioural model.
module tb_zx_mem_mapper;

  localparam int K_IDLE = 0;
  localparam int K_MRD  = 1;
  localparam int K_MWR  = 2;
  localparam int K_IORD = 3;
  localparam int K_IOWR = 4;
  localparam int K_RFSH = 5;

  logic clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  logic        reset;
  logic [15:0] A;
  logic [7:0]  D_in, rom_q, ram_q, ula_data;
  logic        nMREQ, nIORQ, nRD, nWR;

  logic [7:0]  d_out0, d_out1, d_out2;
  logic        d_oe0, d_oe1, d_oe2;
  logic [14:0] rom_addr0, rom_addr1, rom_addr2;
  logic [16:0] ram_addr0, ram_addr1;
  logic [15:0] ram_addr2;
  logic        ram_we0, ram_we1, ram_we2;
  logic        screen_page0, screen_page1, screen_page2;
  logic [5:0]  page_reg0, page_reg1, page_reg2;
  logic        nWAIT0, nWAIT1, nWAIT2;

  // u0: 128K with 3 wait states; u1: fixed 48K map; u2: 4 pages, single ROM, 1 wait state
  zx_mem_mapper #(.RAM_PAGES(8), .ROM_BANKS(2), .WAIT_STATES(3), .MODE_48K(1'b0)) u0 (
    .clk_cpu(clk_cpu), .reset(reset), .A(A), .D_in(D_in), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .rom_q(rom_q), .ram_q(ram_q), .ula_data(ula_data),
    .d_out(d_out0), .d_oe(d_oe0), .rom_addr(rom_addr0), .ram_addr(ram_addr0), .ram_we(ram_we0),
    .screen_page(screen_page0), .page_reg(page_reg0), .nWAIT(nWAIT0));

  zx_mem_mapper #(.RAM_PAGES(8), .ROM_BANKS(2), .WAIT_STATES(0), .MODE_48K(1'b1)) u1 (
    .clk_cpu(clk_cpu), .reset(reset), .A(A), .D_in(D_in), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .rom_q(rom_q), .ram_q(ram_q), .ula_data(ula_data),
    .d_out(d_out1), .d_oe(d_oe1), .rom_addr(rom_addr1), .ram_addr(ram_addr1), .ram_we(ram_we1),
    .screen_page(screen_page1), .page_reg(page_reg1), .nWAIT(nWAIT1));

  zx_mem_mapper #(.RAM_PAGES(4), .ROM_BANKS(1), .WAIT_STATES(1), .MODE_48K(1'b0)) u2 (
    .clk_cpu(clk_cpu), .reset(reset), .A(A), .D_in(D_in), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .rom_q(rom_q), .ram_q(ram_q), .ula_data(ula_data),
    .d_out(d_out2), .d_oe(d_oe2), .rom_addr(rom_addr2), .ram_addr(ram_addr2), .ram_we(ram_we2),
    .screen_page(screen_page2), .page_reg(page_reg2), .nWAIT(nWAIT2));

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance
  int m_page[3];
  int m_prev[3];
  int m_rem[3];
  int m_served[3];

  function automatic int cfg_pages(input int i);
    return (i == 2) ? 4 : 8;
  endfunction
  function automatic int cfg_banks(input int i);
    return (i == 2) ? 1 : 2;
  endfunction
  function automatic int cfg_ws(input int i);
    return (i == 0) ? 3 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic bit cfg_48k(input int i);
    return (i == 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently on the bus
  task automatic model_edge();
    bit hit, qual;
    hit  = ((A & 16'h8002) == (16'h7FFD & 16'h8002)) && !nIORQ && !nWR;
    qual = !nMREQ && (!nRD || !nWR) && (A >= 16'hC000);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_page[i] = 0; m_prev[i] = 0; m_rem[i] = 0; m_served[i] = 0;
      end else begin
        if (hit && m_prev[i] == 0 && !cfg_48k(i) && (m_page[i] & 32) == 0)
          m_page[i] = int'(D_in) & 63;
        m_prev[i] = hit ? 1 : 0;
        if (nMREQ) begin
          m_rem[i] = 0; m_served[i] = 0;
        end else if (m_served[i] == 0 && qual) begin
          m_rem[i] = cfg_ws(i); m_served[i] = 1;
        end else if (m_rem[i] > 0) begin
          m_rem[i]--;
        end
      end
    end
  endtask

  task automatic check_inst(input int i);
    int region, off, bank, pg, e_dout, e_doe, e_we;
    logic [31:0] o_rom, o_ram, o_we, o_dout, o_doe, o_pg, o_scr, o_nw;
    case (i)
      0: begin o_rom = 32'(rom_addr0); o_ram = 32'(ram_addr0); o_we = 32'(ram_we0); o_dout = 32'(d_out0);
               o_doe = 32'(d_oe0); o_pg = 32'(page_reg0); o_scr = 32'(screen_page0); o_nw = 32'(nWAIT0); end
      1: begin o_rom = 32'(rom_addr1); o_ram = 32'(ram_addr1); o_we = 32'(ram_we1); o_dout = 32'(d_out1);
               o_doe = 32'(d_oe1); o_pg = 32'(page_reg1); o_scr = 32'(screen_page1); o_nw = 32'(nWAIT1); end
      default: begin o_rom = 32'(rom_addr2); o_ram = 32'(ram_addr2); o_we = 32'(ram_we2); o_dout = 32'(d_out2);
               o_doe = 32'(d_oe2); o_pg = 32'(page_reg2); o_scr = 32'(screen_page2); o_nw = 32'(nWAIT2); end
    endcase
    region = int'(A) / 16384;
    off    = int'(A) % 16384;
    bank   = (cfg_banks(i) == 2) ? ((m_page[i] / 16) % 2) : 0;
    pg     = (region == 1) ? 5 : ((region == 2) ? 2 : (m_page[i] % 8));
    pg     = pg % cfg_pages(i);
    e_we   = (!nMREQ && !nWR && region != 0) ? 1 : 0;
    if (!nMREQ && !nRD) begin
      e_dout = (region == 0) ? int'(rom_q) : int'(ram_q); e_doe = 1;
    end else if (!nIORQ && !nRD) begin
      e_dout = int'(ula_data); e_doe = 1;
    end else begin
      e_dout = 255; e_doe = 0;
    end
    check_eq($sformatf("u%0d.rom_addr", i), o_rom, bank * 16384 + off);
    if (region != 0) check_eq($sformatf("u%0d.ram_addr", i), o_ram, pg * 16384 + off);
    check_eq($sformatf("u%0d.ram_we", i), o_we, e_we);
    check_eq($sformatf("u%0d.d_oe", i), o_doe, e_doe);
    check_eq($sformatf("u%0d.d_out", i), o_dout, e_dout);
    check_eq($sformatf("u%0d.page_reg", i), o_pg, m_page[i]);
    check_eq($sformatf("u%0d.screen_page", i), o_scr, (m_page[i] / 8) % 2);
    check_eq($sformatf("u%0d.nWAIT", i), o_nw, (m_rem[i] == 0) ? 1 : 0);
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  // One clock: check before the edge (old state), clock, check after the edge
  task automatic step();
    #1 check_all();
    @(posedge clk_cpu);
    model_edge();
    #1 check_all();
    @(negedge clk_cpu);
  endtask

  task automatic bus(input logic [15:0] a, input logic [7:0] d, input int kind);
    A = a; D_in = d;
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    case (kind)
      K_MRD:  begin nMREQ = 1'b0; nRD = 1'b0; end
      K_MWR:  begin nMREQ = 1'b0; nWR = 1'b0; end
      K_IORD: begin nIORQ = 1'b0; nRD = 1'b0; end
      K_IOWR: begin nIORQ = 1'b0; nWR = 1'b0; end
      K_RFSH: begin nMREQ = 1'b0; end
      default: ;
    endcase
  endtask

  initial begin
    logic [4:0]  wv;
    logic        any_low;
    logic [15:0] ra;
    logic [7:0]  rd;
    int          kind, len, gap;

    for (int i = 0; i < 3; i++) begin
      m_page[i] = 0; m_prev[i] = 0; m_rem[i] = 0; m_served[i] = 0;
    end
    reset = 1'b1;
    rom_q = 8'h3C; ram_q = 8'hC3; ula_data = 8'h5A;
    bus(16'h0000, 8'h00, K_IDLE);
    @(negedge clk_cpu);
    step(); step();
    reset = 1'b0;
    step();
    check_eq("reset page_reg", 32'(page_reg0), 32'h0);
    check_eq("reset nWAIT", 32'(nWAIT0), 32'h1);

    // Read C123 after reset; nWAIT low exactly 3 cycles starting one edge in
    bus(16'hC123, 8'h00, K_MRD);
    for (int k = 0; k < 5; k++) begin
      step();
      wv[k] = nWAIT0;
      if (k == 0) begin
        check_eq("c000 ram_addr page0", 32'(ram_addr0), 32'h00123);
        check_eq("c000 rom_addr bank0", 32'(rom_addr0), 32'h0123);
      end
    end
    check_eq("wait3 pattern", 32'(wv), 32'h18);
    bus(16'h0000, 8'h00, K_IDLE); step();

    // Read 8000: no wait states
    bus(16'h8000, 8'h00, K_MRD);
    any_low = 1'b0;
    for (int k = 0; k < 4; k++) begin step(); any_low = any_low | !nWAIT0; end
    check_eq("no wait 8000", 32'(any_low), 32'h0);
    bus(16'h0000, 8'h00, K_IDLE); step();

    // OUT (7FFD),13 -> page 3, ROM bank 1, screen 0
    bus(16'h7FFD, 8'h13, K_IOWR); step();
    check_eq("page_reg 13", 32'(page_reg0), 32'h13);
    step();
    bus(16'h0000, 8'h00, K_IDLE); step();
    check_eq("screen_page 0", 32'(screen_page0), 32'h0);
    bus(16'hC010, 8'h00, K_MRD); step();
    check_eq("c000 page3", 32'(ram_addr0), 32'h0C010);
    bus(16'h0000, 8'h00, K_IDLE); step(); step(); step();
    bus(16'h0010, 8'h00, K_MRD); step();
    check_eq("rom bank1", 32'(rom_addr0), 32'h4010);
    bus(16'h4010, 8'h00, K_MRD); step();
    check_eq("4000 page5", 32'(ram_addr0), 32'h14010);
    bus(16'h0000, 8'h00, K_IDLE); step();

    // Lock then attempt a write; only reset clears
    bus(16'h7FFD, 8'h20, K_IOWR); step();
    bus(16'h0000, 8'h00, K_IDLE); step();
    bus(16'h7FFD, 8'h07, K_IOWR); step();
    bus(16'h0000, 8'h00, K_IDLE); step();
    check_eq("locked page_reg", 32'(page_reg0), 32'h20);
    reset = 1'b1; step(); reset = 1'b0; step();
    check_eq("unlock by reset", 32'(page_reg0), 32'h0);

    // 48K build ignores writes
    bus(16'h7FFD, 8'h07, K_IOWR); step();
    bus(16'h0000, 8'h00, K_IDLE); step();
    check_eq("48k page_reg", 32'(page_reg1), 32'h0);
    check_eq("128k page_reg 07", 32'(page_reg0), 32'h07);

    // Page 6 on a 4-page build wraps to page 2
    bus(16'h7FFD, 8'h06, K_IOWR); step();
    bus(16'h0000, 8'h00, K_IDLE); step();
    bus(16'hC055, 8'h00, K_MRD); step();
    check_eq("4pg wrap", 32'(ram_addr2), 32'h8055);
    check_eq("8pg page6", 32'(ram_addr0), 32'h18055);
    bus(16'h0000, 8'h00, K_IDLE); step(); step(); step();

    // Write strobes and I/O read
    bus(16'h0123, 8'hAA, K_MWR); step();
    check_eq("rom write dropped", 32'(ram_we0), 32'h0);
    bus(16'h4123, 8'hAA, K_MWR); step();
    check_eq("4000 write we", 32'(ram_we0), 32'h1);
    check_eq("4000 write addr", 32'(ram_addr0), 32'h14123);
    bus(16'h00FE, 8'h00, K_IORD); step();
    check_eq("io read d_out", 32'(d_out0), 32'h5A);
    check_eq("io read d_oe", 32'(d_oe0), 32'h1);
    bus(16'h0000, 8'h00, K_IDLE); step();
    check_eq("idle d_out", 32'(d_out0), 32'hFF);

    // Reset in the middle of a wait burst
    bus(16'hC000, 8'h00, K_MRD); step();
    check_eq("wait started", 32'(nWAIT0), 32'h0);
    reset = 1'b1; step();
    check_eq("reset releases nWAIT", 32'(nWAIT0), 32'h1);
    bus(16'h0000, 8'h00, K_IDLE); step();
    reset = 1'b0; step();

    // Random bus traffic
    for (int t = 0; t < 1500; t++) begin
      kind = int'($urandom_range(0, 5));
      ra   = 16'($urandom);
      if (kind == K_IOWR && $urandom_range(0, 1) == 1) ra = 16'h7FFD;
      rd    = 8'($urandom);
      rd[5] = ($urandom_range(0, 7) == 0);
      rom_q = 8'($urandom); ram_q = 8'($urandom); ula_data = 8'($urandom);
      reset = ($urandom_range(0, 59) == 0);
      bus(ra, rd, kind);
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        step();
        reset = 1'b0;
      end
      bus(ra, rd, K_IDLE);
      gap = int'($urandom_range(1, 2));
      for (int k = 0; k < gap; k++) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
